// File: rtl/amo_sequencer.sv
// amo_sequencer: RV32A atomic-memory-operation sequencer.
// Runs LR/SC and AMO read-modify-write operations against a single-port data
// memory. It keeps one LR reservation and stalls the pipeline while it works.
// Ports:
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_start, i_funct5             atomic issue strobe and operation select
//   i_addr, i_wdata               effective address (rs1) and rs2 operand
//   i_clear_resv                  trap/xRET, drops the reservation
//   i_snoop_we, i_snoop_addr      regular store commit, used for reservation snooping
//   o_mem_req/we/addr/wdata       data-memory request, held until i_mem_ack
//   i_mem_ack, i_mem_rdata        data-memory response
//   o_busy                        pipeline stall request
//   o_done, o_illegal, o_misaligned  completion pulse and exception pulses
//   o_rdata                       rd result, held until the next accepted start
module amo_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic [4:0]      i_funct5,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_clear_resv,
    input  logic            i_snoop_we,
    input  logic [XLEN-1:0] i_snoop_addr,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_illegal,
    output logic            o_misaligned
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000, OP_SWAP = 5'b00001, OP_LR   = 5'b00010,
        OP_SC   = 5'b00011, OP_XOR  = 5'b00100, OP_OR   = 5'b01000,
        OP_AND  = 5'b01100, OP_MIN  = 5'b10000, OP_MAX  = 5'b10100,
        OP_MINU = 5'b11000, OP_MAXU = 5'b11100
    } op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [XLEN-3:0]   word_q, word_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              resv_valid_q, resv_valid_d;
    logic [XLEN-3:0]   resv_addr_q, resv_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;
    logic              misaligned_q, misaligned_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic              snoop_hit;
    logic              resv_kill;

    function automatic logic is_legal(input logic [4:0] f);
        case (f)
            OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: is_legal = 1'b1;
            default:                          is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] amo_alu(input op_e op, input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] opnd);
        case (op)
            OP_ADD:  amo_alu = old + opnd;
            OP_XOR:  amo_alu = old ^ opnd;
            OP_AND:  amo_alu = old & opnd;
            OP_OR:   amo_alu = old | opnd;
            OP_MIN:  amo_alu = ($signed(old) < $signed(opnd)) ? old : opnd;
            OP_MAX:  amo_alu = ($signed(old) > $signed(opnd)) ? old : opnd;
            OP_MINU: amo_alu = (old < opnd) ? old : opnd;
            OP_MAXU: amo_alu = (old > opnd) ? old : opnd;
            default: amo_alu = opnd;  // SWAP
        endcase
    endfunction

    // Snoop compares word addresses; the byte offset of the store is irrelevant.
    assign snoop_hit = i_snoop_we && ((i_snoop_addr >> 2) == XLEN'(resv_addr_q));
    // A kill in the same cycle as an SC start makes that SC fail.
    assign resv_kill = i_clear_resv || snoop_hit;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        misaligned_d = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    op_d       = op_e'(i_funct5);
                    word_d     = i_addr[XLEN-1:2];
                    wdata_d    = i_wdata;
                    mem_addr_d = {i_addr[XLEN-1:2], 2'b00};
                    if (!is_legal(i_funct5)) begin
                        state_d   = RESP;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                    end else if (i_addr[1:0] != 2'b00) begin
                        state_d      = RESP;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                        if (i_funct5 == OP_SC) resv_valid_d = 1'b0;
                    end else if (i_funct5 == OP_SC) begin
                        if (resv_valid_q && !resv_kill && resv_addr_q == i_addr[XLEN-1:2]) begin
                            state_d     = WRITE;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = i_wdata;
                        end else begin
                            state_d      = RESP;
                            done_d       = 1'b1;
                            rdata_d      = {{(XLEN-1){1'b0}}, 1'b1};
                            resv_valid_d = 1'b0;
                        end
                    end else begin
                        state_d   = READ;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end
                end
            end
            READ: begin
                if (i_mem_ack) begin
                    rdata_d = i_mem_rdata;
                    if (op_q == OP_LR) begin
                        state_d      = RESP;
                        done_d       = 1'b1;
                        mem_req_d    = 1'b0;
                        resv_valid_d = 1'b1;
                        resv_addr_d  = word_q;
                    end else begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = amo_alu(op_q, i_mem_rdata, wdata_q);
                    end
                end
            end
            WRITE: begin
                if (i_mem_ack) begin
                    state_d   = RESP;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (op_q == OP_SC) begin
                        rdata_d      = '0;
                        resv_valid_d = 1'b0;
                    end else if (resv_addr_q == word_q) begin
                        resv_valid_d = 1'b0;
                    end
                end
            end
            default: begin  // RESP
                state_d = IDLE;
            end
        endcase

        // Trap/xRET and snooped stores win over an LR setting the reservation.
        if (resv_kill) resv_valid_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= IDLE;
            op_q         <= OP_ADD;
            word_q       <= '0;
            wdata_q      <= '0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
            rdata_q      <= rdata_d;
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_done       = done_q;
    assign o_illegal    = illegal_q;
    assign o_misaligned = misaligned_q;
    assign o_rdata      = rdata_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Testbench for amo_sequencer: memory responder with programmable ack delay,
// an architectural reference model (reservation + memory image) and
// directed plus randomized scenarios.
module tb_amo_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_start;
    logic [4:0]  i_funct5;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_clear_resv;
    logic        i_snoop_we;
    logic [31:0] i_snoop_addr;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_illegal;
    logic        o_misaligned;

    amo_sequencer #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_funct5(i_funct5),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_clear_resv(i_clear_resv),
        .i_snoop_we(i_snoop_we), .i_snoop_addr(i_snoop_addr),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata),
        .o_illegal(o_illegal), .o_misaligned(o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010,
                           F_SC = 5'b00011, F_XOR = 5'b00100, F_OR = 5'b01000,
                           F_AND = 5'b01100, F_MIN = 5'b10000, F_MAX = 5'b10100,
                           F_MINU = 5'b11000, F_MAXU = 5'b11100;

    int checks = 0;
    int errors = 0;

    // memory responder state
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          wr_cnt    = 0;
    int          req_cnt   = 0;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    // reference model state
    bit          m_rv;
    logic [29:0] m_ra;
    logic [31:0] m_rdata;

    always @(negedge i_clk) begin
        i_mem_ack = 1'b0;
        if (!i_rstn || !o_mem_req) begin
            wait_cnt = 0;
        end else begin
            req_cnt++;
            if (wait_cnt >= ack_delay) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem[o_mem_addr[9:2]];
                if (o_mem_we) begin
                    mem[o_mem_addr[9:2]] = o_mem_wdata;
                    wr_cnt++;
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Architectural effect of one atomic instruction; nacc = memory accesses.
    task automatic predict(input logic [4:0] f, input logic [31:0] a, input logic [31:0] w,
                           input bit clr, output logic [31:0] erd, output bit eill,
                           output bit emis, output int nacc);
        logic [31:0] old;
        logic [31:0] nw;
        int          idx;
        idx  = int'(a[9:2]);
        eill = 1'b0;
        emis = 1'b0;
        nacc = 0;
        if (clr) m_rv = 1'b0;
        if (!(f inside {F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                        F_MIN, F_MAX, F_MINU, F_MAXU})) begin
            eill = 1'b1;
        end else if (a[1:0] != 2'b00) begin
            emis = 1'b1;
            if (f == F_SC) m_rv = 1'b0;
        end else if (f == F_LR) begin
            m_rdata = ref_mem[idx];
            m_rv    = 1'b1;
            m_ra    = a[31:2];
            nacc    = 1;
        end else if (f == F_SC) begin
            if (m_rv && m_ra == a[31:2]) begin
                ref_mem[idx] = w;
                m_rdata      = 32'd0;
                nacc         = 1;
            end else begin
                m_rdata = 32'd1;
            end
            m_rv = 1'b0;
        end else begin
            old = ref_mem[idx];
            case (f)
                F_ADD:   nw = old + w;
                F_XOR:   nw = old ^ w;
                F_AND:   nw = old & w;
                F_OR:    nw = old | w;
                F_MIN:   nw = ($signed(old) < $signed(w)) ? old : w;
                F_MAX:   nw = ($signed(old) > $signed(w)) ? old : w;
                F_MINU:  nw = (old < w) ? old : w;
                F_MAXU:  nw = (old > w) ? old : w;
                default: nw = w;
            endcase
            ref_mem[idx] = nw;
            m_rdata      = old;
            nacc         = 2;
            if (m_rv && m_ra == a[31:2]) m_rv = 1'b0;
        end
        erd = m_rdata;
    endtask

    // Issue one instruction at a negedge; returns cycles from start to done.
    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] w,
                         input bit clr, output int lat, output logic [31:0] rd,
                         output bit ill, output bit mis, output bit to);
        i_start = 1'b1; i_funct5 = f; i_addr = a; i_wdata = w; i_clear_resv = clr;
        lat = 0; to = 1'b1; rd = '0; ill = 1'b0; mis = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(posedge i_clk);
            lat++;
            @(negedge i_clk);
            i_start = 1'b0; i_clear_resv = 1'b0;
            if (o_done === 1'b1) begin
                rd = o_rdata; ill = o_illegal; mis = o_misaligned; to = 1'b0;
                break;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic snoop(input logic [31:0] a);
        i_snoop_we = 1'b1; i_snoop_addr = a;
        @(posedge i_clk);
        @(negedge i_clk);
        i_snoop_we = 1'b0;
        if (m_rv && m_ra == a[31:2]) m_rv = 1'b0;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_start = 1'b0; i_funct5 = '0; i_addr = '0; i_wdata = '0;
        i_clear_resv = 1'b0; i_snoop_we = 1'b0; i_snoop_addr = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        m_rv = 1'b0; m_ra = '0; m_rdata = '0;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_mem_req, o_mem_we, o_busy, o_done, o_illegal, o_misaligned} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {o_mem_req, o_mem_we, o_busy, o_done, o_illegal, o_misaligned});
        end
        checks++;
        if (o_mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", o_mem_addr); end
        checks++;
        if (o_mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", o_mem_wdata); end
        checks++;
        if (o_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", o_rdata); end
        i_rstn = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_lr_sc();
        logic [31:0] rd, erd; bit ill, mis, to, eill, emis; int lat, nacc, w0;
        mem[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
        predict(F_LR, 32'h100, 32'd0, 1'b0, erd, eill, emis, nacc);
        issue(F_LR, 32'h100, 32'd0, 1'b0, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 2 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lr_basic lat=%0d rd=%h to=%0d exp lat=2 rd=deadbeef", lat, rd, to);
        end
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle done=%b busy=%b exp 0 0", o_done, o_busy);
        end
        w0 = wr_cnt;
        predict(F_SC, 32'h100, 32'd5, 1'b0, erd, eill, emis, nacc);
        issue(F_SC, 32'h100, 32'd5, 1'b0, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 2 || rd !== 32'd0 || mem[8'h40] !== 32'd5 || wr_cnt != w0 + 1) begin
            errors++; $display("FAIL sc_pass lat=%0d rd=%h mem=%h exp lat=2 rd=0 mem=5", lat, rd, mem[8'h40]);
        end
    endtask

    task automatic test_snoop_clear();
        logic [31:0] rd, erd; bit ill, mis, to, eill, emis; int lat, nacc, w0;
        predict(F_LR, 32'h100, 32'd0, 1'b0, erd, eill, emis, nacc);
        issue(F_LR, 32'h100, 32'd0, 1'b0, lat, rd, ill, mis, to);
        snoop(32'h102);
        w0 = wr_cnt;
        predict(F_SC, 32'h100, 32'd9, 1'b0, erd, eill, emis, nacc);
        issue(F_SC, 32'h100, 32'd9, 1'b0, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 1 || rd !== 32'd1 || wr_cnt != w0) begin
            errors++; $display("FAIL sc_after_snoop lat=%0d rd=%h writes=%0d exp lat=1 rd=1 writes=0", lat, rd, wr_cnt - w0);
        end
        predict(F_LR, 32'h104, 32'd0, 1'b0, erd, eill, emis, nacc);
        issue(F_LR, 32'h104, 32'd0, 1'b0, lat, rd, ill, mis, to);
        predict(F_SC, 32'h104, 32'd7, 1'b1, erd, eill, emis, nacc);
        issue(F_SC, 32'h104, 32'd7, 1'b1, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 1 || rd !== 32'd1 || wr_cnt != w0) begin
            errors++; $display("FAIL sc_with_clear lat=%0d rd=%h exp lat=1 rd=1", lat, rd);
        end
    endtask

    task automatic test_minmax();
        logic [31:0] rd, erd; bit ill, mis, to, eill, emis; int lat, nacc;
        mem[8'h80] = 32'd3; ref_mem[8'h80] = 32'd3;
        predict(F_MIN, 32'h200, 32'hFFFFFFFF, 1'b0, erd, eill, emis, nacc);
        issue(F_MIN, 32'h200, 32'hFFFFFFFF, 1'b0, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 3 || rd !== 32'd3 || mem[8'h80] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL amomin lat=%0d rd=%h mem=%h exp lat=3 rd=3 mem=ffffffff", lat, rd, mem[8'h80]);
        end
        mem[8'h80] = 32'd3; ref_mem[8'h80] = 32'd3;
        predict(F_MINU, 32'h200, 32'hFFFFFFFF, 1'b0, erd, eill, emis, nacc);
        issue(F_MINU, 32'h200, 32'hFFFFFFFF, 1'b0, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 3 || rd !== 32'd3 || mem[8'h80] !== 32'd3) begin
            errors++; $display("FAIL amominu lat=%0d rd=%h mem=%h exp lat=3 rd=3 mem=3", lat, rd, mem[8'h80]);
        end
    endtask

    task automatic test_delayed_ack();
        logic [31:0] erd; bit eill, emis, done, held; int lat, nacc;
        logic [65:0] prev;
        mem[8'h90] = 32'hFFFFFFF0; ref_mem[8'h90] = 32'hFFFFFFF0;
        ack_delay = 3;
        predict(F_ADD, 32'h240, 32'h25, 1'b0, erd, eill, emis, nacc);
        i_start = 1'b1; i_funct5 = F_ADD; i_addr = 32'h240; i_wdata = 32'h25;
        lat = 0; done = 1'b0; held = 1'b0; prev = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            lat++;
            @(negedge i_clk);
            i_start = 1'b0;
            #1;
            if (o_done === 1'b1) begin done = 1'b1; break; end
            checks++;
            if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_during_op cycle=%0d got=%b exp=1", lat, o_busy); end
            if (held) begin
                checks++;
                if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata} !== prev) begin
                    errors++;
                    $display("FAIL req_stable cycle=%0d got=%h exp=%h", lat,
                             {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}, prev);
                end
            end
            prev = {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata};
            held = o_mem_req && !i_mem_ack;
        end
        checks++;
        if (!done || lat != 9 || o_rdata !== 32'hFFFFFFF0 || mem[8'h90] !== 32'h15) begin
            errors++; $display("FAIL amoadd_delayed done=%0d lat=%0d rd=%h mem=%h exp lat=9 rd=fffffff0 mem=15",
                               done, lat, o_rdata, mem[8'h90]);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        ack_delay = 0;
    endtask

    task automatic test_illegal_misaligned();
        logic [31:0] rd, erd; bit ill, mis, to, eill, emis; int lat, nacc, r0;
        r0 = req_cnt;
        predict(5'b11111, 32'h100, 32'd1, 1'b0, erd, eill, emis, nacc);
        issue(5'b11111, 32'h100, 32'd1, 1'b0, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 1 || !ill || mis || rd !== erd || req_cnt != r0) begin
            errors++; $display("FAIL illegal lat=%0d ill=%0d mis=%0d rd=%h reqs=%0d exp lat=1 ill=1 mis=0 rd=%h reqs=0",
                               lat, ill, mis, rd, req_cnt - r0, erd);
        end
        predict(F_LR, 32'h101, 32'd0, 1'b0, erd, eill, emis, nacc);
        issue(F_LR, 32'h101, 32'd0, 1'b0, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 1 || ill || !mis || req_cnt != r0) begin
            errors++; $display("FAIL misaligned lat=%0d ill=%0d mis=%0d reqs=%0d exp lat=1 ill=0 mis=1 reqs=0",
                               lat, ill, mis, req_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; bit ill, mis, to, eill, emis, hit; int lat, nacc, w0;
        predict(F_LR, 32'h180, 32'd0, 1'b0, erd, eill, emis, nacc);
        issue(F_LR, 32'h180, 32'd0, 1'b0, lat, rd, ill, mis, to);
        w0 = wr_cnt;
        ack_delay = 5;
        i_start = 1'b1; i_funct5 = F_ADD; i_addr = 32'h184; i_wdata = 32'h11;
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_mem_req === 1'b1 && o_mem_we === 1'b1) begin hit = 1'b1; break; end
        end
        i_rstn = 1'b0;
        #1;
        checks++;
        if (!hit || o_mem_req !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_write reached=%0d req=%b busy=%b exp req=0 busy=0", hit, o_mem_req, o_busy);
        end
        m_rv = 1'b0; m_rdata = 32'd0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        ack_delay = 0;
        @(negedge i_clk);
        predict(F_SC, 32'h180, 32'd3, 1'b0, erd, eill, emis, nacc);
        issue(F_SC, 32'h180, 32'd3, 1'b0, lat, rd, ill, mis, to);
        checks++;
        if (to || lat != 1 || rd !== 32'd1 || wr_cnt != w0 || mem[8'h61] !== ref_mem[8'h61]) begin
            errors++; $display("FAIL sc_after_reset lat=%0d rd=%h writes=%0d exp lat=1 rd=1 writes=0", lat, rd, wr_cnt - w0);
        end
    endtask

    task automatic test_random();
        logic [4:0]  ops [11];
        logic [31:0] rd, erd, a, w;
        logic [4:0]  f;
        bit          ill, mis, to, eill, emis, clr;
        int          lat, nacc, idx;
        ops = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU};
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) f = 5'($urandom);
            else if ($urandom_range(0, 2) == 0) f = F_SC;
            else if ($urandom_range(0, 3) == 0) f = F_LR;
            else f = ops[$urandom_range(0, 10)];
            a = 32'h300 + (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 11) == 0) a = a | 32'($urandom_range(1, 3));
            w = $urandom;
            clr = ($urandom_range(0, 15) == 0);
            ack_delay = $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0)
                snoop(32'h300 + 32'($urandom_range(0, 15)));
            checks++;
            if (o_rdata !== m_rdata) begin
                errors++; $display("FAIL rdata_hold op=%0d got=%h exp=%h", n, o_rdata, m_rdata);
            end
            predict(f, a, w, clr, erd, eill, emis, nacc);
            issue(f, a, w, clr, lat, rd, ill, mis, to);
            idx = int'(a[9:2]);
            checks++;
            if (to || rd !== erd || ill != eill || mis != emis || lat != 1 + nacc * (1 + ack_delay)
                || mem[idx] !== ref_mem[idx]) begin
                errors++;
                $display("FAIL random op=%0d f=%b a=%h to=%0d rd=%h/%h ill=%0d/%0d mis=%0d/%0d lat=%0d/%0d mem=%h/%h",
                         n, f, a, to, rd, erd, ill, eill, mis, emis, lat, 1 + nacc * (1 + ack_delay),
                         mem[idx], ref_mem[idx]);
            end
        end
        ack_delay = 0;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_lr_sc();
        test_snoop_clear();
        test_minmax();
        test_delayed_ack();
        test_illegal_misaligned();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amo_sequencer.md
AMO_SEQUENCER -- requirements
Module: amo_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width; only 32 is supported.
REQ-002 SHALL have port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port i_start, input, 1, atomic instruction issued (decoder atomic flag, pipeline not stalled).
REQ-005 SHALL have port i_funct5, input, 5, instruction bits [31:27], selecting the atomic operation.
REQ-006 SHALL have port i_addr, input, XLEN, effective address (rs1).
REQ-007 SHALL have port i_wdata, input, XLEN, rs2 operand.
REQ-008 SHALL have port i_clear_resv, input, 1, trap or xRET, which invalidates the reservation.
REQ-009 SHALL have ports i_snoop_we (input, 1) and i_snoop_addr (input, XLEN), a regular store committing to memory.
REQ-010 SHALL have ports o_mem_req (output, 1), o_mem_we (output, 1), o_mem_addr (output, XLEN) and o_mem_wdata (output, XLEN), the data-memory request.
REQ-011 SHALL have ports i_mem_ack (input, 1) and i_mem_rdata (input, XLEN), the data-memory response.
REQ-012 SHALL have port o_busy, output, 1, pipeline stall request.
REQ-013 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port o_rdata, output, XLEN, value for rd.
REQ-015 SHALL have ports o_illegal (output, 1) and o_misaligned (output, 1), exception pulses coincident with o_done.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE, RESP; o_busy = (state != IDLE).
REQ-017 SHALL, in IDLE with i_start=1, latch funct5, addr[31:2], and wdata; i_start SHALL be ignored in all other states.
REQ-018 SHALL decode the following funct5 values: LR=00010, SC=00011, SWAP=00001, ADD=00000, XOR=00100, AND=01100, OR=01000, MIN=10000, MAX=10100, MINU=11000, MAXU=11100.
REQ-019 SHALL, for any other funct5 value, go IDLE->RESP without a memory access, with o_illegal=1 and o_rdata unchanged.
REQ-020 SHALL, when i_addr[1:0] != 0, go IDLE->RESP without a memory access, with o_misaligned=1; this check has priority below illegal.
REQ-021 SHALL, in READ and WRITE, hold o_mem_req=1 with addr/we/wdata stable until i_mem_ack; an ack SHALL be accepted in the same cycle as req.
REQ-022 SHALL, for LR: READ; on ack, capture rdata into o_rdata, set reservation valid with the word address, then go to RESP.
REQ-023 SHALL, for SC with reservation valid and word address match: WRITE of wdata, with o_rdata=0 on ack.
REQ-024 SHALL, for SC on mismatch or invalid reservation: go IDLE->RESP directly, with o_rdata=1 and no memory access.
REQ-025 SHALL clear the reservation when any SC reaches RESP, whether it passed or failed.
REQ-026 SHALL, for AMO ops: READ; on ack, o_rdata=old value and compute new = op(old, wdata); then WRITE new; on ack go to RESP.
REQ-027 SHALL compute MIN/MAX as signed 32-bit comparisons and MINU/MAXU as unsigned; ADD SHALL wrap modulo 2^32.
REQ-028 SHALL assert o_done exactly one cycle, in RESP, then return to IDLE.
REQ-029 SHALL give the following latencies with zero-wait ack: LR 2 cycles, AMO 3 cycles, and SC-pass 2 cycles from start to done; SC-fail, illegal, and misaligned 1 cycle.
REQ-030 SHALL hold o_rdata stable from o_done until the next accepted i_start.
REQ-031 SHALL clear the reservation on i_clear_resv in any state; if i_clear_resv coincides with an SC start, the SC SHALL fail.
REQ-032 SHALL clear the reservation on i_snoop_we with a matching word address; the sequencer's own AMO WRITE to the reserved word SHALL also clear it.
REQ-033 SHALL drive o_mem_we=1 only in WRITE.
REQ-034 SHALL hold o_mem_req=0 in IDLE and RESP.

Reset
REQ-035 SHALL, on i_rstn=0 at any time, including mid-transaction, immediately force state=IDLE.
REQ-036 SHALL, on reset, drive o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0, o_done=0, o_illegal=0, o_misaligned=0, and o_rdata=0, and set the reservation invalid.
REQ-037 SHALL leave any memory request abandoned by reset unretried.

Verification
REQ-038 SHALL cover: LR 0x100 with mem[0x100]=0xDEADBEEF and zero-wait ack -> o_done at cycle 2, o_rdata=0xDEADBEEF; then SC 0x100 with wdata 5 -> write 5, o_rdata=0.
REQ-039 SHALL cover: LR 0x100, then i_snoop_we to 0x102, then SC 0x100 -> no write, o_rdata=1, and done 1 cycle after start.
REQ-040 SHALL cover: AMOMIN at 0x200 with mem=0x00000003 and wdata=0xFFFFFFFF -> write 0xFFFFFFFF, o_rdata=3; the same case with AMOMINU -> write 3.
REQ-041 SHALL cover: AMOADD with ack delayed 3 cycles in both READ and WRITE -> req, addr, and wdata stable throughout, o_busy high until done, and mem=old+wdata mod 2^32.
REQ-042 SHALL cover: funct5=11111 -> o_illegal and o_done in the same cycle with no o_mem_req; i_addr=0x101 with LR -> o_misaligned and no o_mem_req.
REQ-043 SHALL cover: i_rstn low during AMO WRITE wait -> o_mem_req=0 and o_busy=0 immediately; a following SC SHALL fail.
